// File: rtl/mips_mem_pkg.sv
// Shared types for the DataMemory arbiter: FSM state encoding and port indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Port index constants; also the encoding of the owner pointer.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that did not own the bus last. Latency: combinational.
// Backpressure: none; the loser simply sees no grant and keeps requesting.
// Ports: req_i[1:0] requests, last_owner_i previous winner, gnt_o[1:0] one-hot (or zero) grant.
module rr_arbiter2
    import mips_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_owner_i == PORT_CPU) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares single-port DataMemory between the CPU port (0) and the debug/DMA port (1).
// Latency: Req sampled at edge N -> Grant in cycle N..N+1 -> Rvalid in cycle N+1..N+2.
// Backpressure: a requester holds Req and qualifiers until its Grant; one access per cycle.
// Ports: clk/reset (async active-low); per port X: ReqX/WeX/AddrX/WdataX in,
//        GrantX/RdataX/RvalidX/ErrX out; memory side: MemWrite/MemRead/Address/WriteData
//        out, ReadData in (combinational read from DataMemory).
module data_memory_arbiter
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  Req0,
    input  logic                  We0,
    input  logic [DATA_WIDTH-1:0] Addr0,
    input  logic [DATA_WIDTH-1:0] Wdata0,
    output logic                  Grant0,
    output logic [DATA_WIDTH-1:0] Rdata0,
    output logic                  Rvalid0,
    output logic                  Err0,

    input  logic                  Req1,
    input  logic                  We1,
    input  logic [DATA_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0] Wdata1,
    output logic                  Grant1,
    output logic [DATA_WIDTH-1:0] Rdata1,
    output logic                  Rvalid1,
    output logic                  Err1,

    output logic                  MemWrite,
    output logic                  MemRead,
    output logic [DATA_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WriteData,
    input  logic [DATA_WIDTH-1:0] ReadData
);

    localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;   // current access owner == last granted port
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [1:0]            rvalid_q, rvalid_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic [1:0]            gnt;
    logic                  access;
    logic                  inrange;
    logic [1:0]            sel;                // which port is on the bus this cycle

    rr_arbiter2 u_arb (
        .req_i        ({Req1, Req0}),
        .last_owner_i (owner_q),
        .gnt_o        (gnt)
    );

    assign access  = (state_q == ACCESS);
    assign inrange = (addr_q < DEPTH_W);
    assign sel[0]  = access && (owner_q == PORT_CPU);
    assign sel[1]  = access && (owner_q == PORT_DBG);

    // Next-state: the same decision is taken from IDLE and from ACCESS, so a
    // new access can follow the previous one with no idle bubble.
    always_comb begin
        state_d = IDLE;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (gnt[0]) begin
            state_d = ACCESS;
            owner_d = PORT_CPU;
            we_d    = We0;
            addr_d  = Addr0;
            wdata_d = Wdata0;
        end else if (gnt[1]) begin
            state_d = ACCESS;
            owner_d = PORT_DBG;
            we_d    = We1;
            addr_d  = Addr1;
            wdata_d = Wdata1;
        end
    end

    // Response capture at the edge that ends an ACCESS cycle; the non-owner
    // port's response registers are cleared so they read as zero.
    always_comb begin
        rvalid_d = sel;
        err_d    = sel & {2{~inrange}};
        rdata0_d = (sel[0] && inrange) ? ReadData : '0;
        rdata1_d = (sel[1] && inrange) ? ReadData : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= PORT_DBG;          // port 0 wins the first tie after reset
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Memory side is gated by the state so IDLE drives all zeros, and an
    // out-of-range address never strobes the memory.
    assign Grant0    = sel[0];
    assign Grant1    = sel[1];
    assign MemWrite  = access &  we_q & inrange;
    assign MemRead   = access & ~we_q & inrange;
    assign Address   = access ? addr_q  : '0;
    assign WriteData = access ? wdata_q : '0;

    assign Rvalid0   = rvalid_q[0];
    assign Rvalid1   = rvalid_q[1];
    assign Err0      = err_q[0];
    assign Err1      = err_q[1];
    assign Rdata0    = rdata0_q;
    assign Rdata1    = rdata1_q;

endmodule
